// File: rtl/deserializer_parallel.sv
// rtl/deserializer_parallel.sv - packs N_SAMPLES handshaked words into one frame held for a downstream handshake
module deserializer_parallel #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter bit LSW_FIRST = 1'b1,
    localparam int CNT_W = ($clog2(N_SAMPLES + 1) < 1) ? 1 : $clog2(N_SAMPLES + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT_WIDTH-1:0]           recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    input  logic                           flush,
    output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg,
    output logic                           send_val,
    input  logic                           send_rdy,
    output logic [CNT_W-1:0]               count
);

    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    logic [BIT_WIDTH-1:0]  r_slot [N_SAMPLES];

    logic                  w_recv_fire;
    logic                  w_send_fire;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_slot;

    // Both ready and valid are masked by reset and flush so neither handshake can fire then.
    assign recv_rdy    = reset & ~flush & ((r_state == S_COLLECT) | send_rdy);
    assign send_val    = reset & ~flush & (r_state == S_FULL);
    assign w_recv_fire = recv_val & recv_rdy;
    assign w_send_fire = send_val & send_rdy;
    assign count       = r_count;

    // A word accepted while FULL is the first word of the next frame.
    assign w_idx  = (r_state == S_FULL) ? '0 : IDX_W'(r_count);
    assign w_slot = LSW_FIRST ? w_idx : (LAST_IDX - w_idx);

    for (genvar g = 0; g < N_SAMPLES; g++) begin : g_pack
        assign send_msg[g*BIT_WIDTH +: BIT_WIDTH] = r_slot[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_COLLECT;
            r_count <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_recv_fire) begin
                r_slot[w_slot] <= recv_msg;
            end
            if (flush) begin
                r_state <= S_COLLECT;
                r_count <= '0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_recv_fire) begin
                            if (r_count == LAST_CNT) begin
                                r_count <= '0;
                                r_state <= S_FULL;
                            end else begin
                                r_count <= r_count + CNT_W'(1);
                            end
                        end
                    end
                    S_FULL: begin
                        if (w_send_fire) begin
                            if (w_recv_fire) begin
                                if (N_SAMPLES > 1) begin
                                    r_count <= CNT_W'(1);
                                    r_state <= S_COLLECT;
                                end
                            end else begin
                                r_count <= '0;
                                r_state <= S_COLLECT;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_COLLECT;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer_parallel.sv
// tb/tb_deserializer_parallel.sv - scoreboard bench for deserializer_parallel
module tb_deserializer_parallel;

    logic        clk;
    logic        rst_n;
    logic [7:0]  recv_msg;
    logic        recv_val;
    logic        flush;
    logic        send_rdy;

    logic        a_recv_rdy, b_recv_rdy;
    logic [31:0] a_send_msg, b_send_msg;
    logic        a_send_val, b_send_val;
    logic [2:0]  a_count, b_count;

    logic [7:0]  c_recv_msg;
    logic        c_recv_val;
    logic        c_recv_rdy;
    logic        c_flush;
    logic [7:0]  c_send_msg;
    logic        c_send_val;
    logic        c_send_rdy;
    logic [0:0]  c_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    deserializer_parallel #(.BIT_WIDTH(8), .N_SAMPLES(4), .LSW_FIRST(1'b1)) u_a (
        .clk(clk), .reset(rst_n), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(a_recv_rdy),
        .flush(flush), .send_msg(a_send_msg), .send_val(a_send_val), .send_rdy(send_rdy), .count(a_count)
    );

    deserializer_parallel #(.BIT_WIDTH(8), .N_SAMPLES(4), .LSW_FIRST(1'b0)) u_b (
        .clk(clk), .reset(rst_n), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(b_recv_rdy),
        .flush(flush), .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(send_rdy), .count(b_count)
    );

    deserializer_parallel #(.BIT_WIDTH(8), .N_SAMPLES(1), .LSW_FIRST(1'b1)) u_c (
        .clk(clk), .reset(rst_n), .recv_msg(c_recv_msg), .recv_val(c_recv_val), .recv_rdy(c_recv_rdy),
        .flush(c_flush), .send_msg(c_send_msg), .send_val(c_send_val), .send_rdy(c_send_rdy), .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every frame handed downstream must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && send_rdy && a_send_val) begin
            if (qa.size() == 0) chk("a_unexpected_frame", a_send_msg, 32'hxxxxxxxx);
            else chk("a_frame", a_send_msg, qa.pop_front());
        end
        if (rst_n && send_rdy && b_send_val) begin
            if (qb.size() == 0) chk("b_unexpected_frame", b_send_msg, 32'hxxxxxxxx);
            else chk("b_frame", b_send_msg, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word; it must be accepted immediately (no bubbles expected here).
    task automatic push(input logic [7:0] d);
        recv_msg = d;
        recv_val = 1'b1;
        @(negedge clk);
        chk("recv_rdy_on_push", {31'd0, a_recv_rdy}, 32'd1);
        tick();
    endtask

    task automatic expect_frame(input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3);
        qa.push_back({w3, w2, w1, w0});
        qb.push_back({w0, w1, w2, w3});
    endtask

    initial begin
        rst_n = 1'b0; recv_msg = '0; recv_val = 1'b0; flush = 1'b0; send_rdy = 1'b1;
        c_recv_msg = '0; c_recv_val = 1'b0; c_flush = 1'b0; c_send_rdy = 1'b1;
        #2;
        chk("rst_send_msg", a_send_msg, 32'd0);
        chk("rst_send_val", {31'd0, a_send_val}, 32'd0);
        chk("rst_count", {29'd0, a_count}, 32'd0);
        chk("rst_recv_rdy", {31'd0, a_recv_rdy}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Basic fill, both slot orders
        expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push(8'h11); chk("cnt_1", {29'd0, a_count}, 32'd1);
        push(8'h22); chk("cnt_2", {29'd0, a_count}, 32'd2);
        push(8'h33); chk("cnt_3", {29'd0, a_count}, 32'd3);
        push(8'h44); chk("cnt_0", {29'd0, a_count}, 32'd0);
        recv_val = 1'b0;
        chk("full_send_val", {31'd0, a_send_val}, 32'd1);
        chk("full_send_val_b", {31'd0, b_send_val}, 32'd1);
        tick();
        chk("after_send_val", {31'd0, a_send_val}, 32'd0);

        // Backpressure
        send_rdy = 1'b0;
        expect_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        recv_msg = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_recv_rdy", {31'd0, a_recv_rdy}, 32'd0);
            chk("bp_send_val", {31'd0, a_send_val}, 32'd1);
            chk("bp_stable", a_send_msg, 32'hA4A3A2A1);
            tick();
            chk("bp_count", {29'd0, a_count}, 32'd0);
        end
        recv_val = 1'b0;
        send_rdy = 1'b1;
        tick();
        chk("bp_released", {31'd0, a_send_val}, 32'd0);

        // Back-to-back turnover
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04);
        expect_frame(8'h05, 8'h06, 8'h07, 8'h08);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        push(8'h05);
        chk("turn_count", {29'd0, a_count}, 32'd1);
        chk("turn_send_val", {31'd0, a_send_val}, 32'd0);
        push(8'h06); push(8'h07); push(8'h08);
        recv_val = 1'b0;
        tick();

        // Flush
        push(8'hAA); push(8'hBB);
        chk("pre_flush_cnt", {29'd0, a_count}, 32'd2);
        recv_msg = 8'hCC;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_recv_rdy", {31'd0, a_recv_rdy}, 32'd0);
        tick();
        flush = 1'b0;
        recv_val = 1'b0;
        chk("flush_count", {29'd0, a_count}, 32'd0);
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        recv_val = 1'b0;
        tick();

        // Asynchronous reset mid-frame
        push(8'h66); push(8'h77);
        recv_val = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", {29'd0, a_count}, 32'd0);
        chk("arst_send_msg", a_send_msg, 32'd0);
        chk("arst_send_msg_b", b_send_msg, 32'd0);
        chk("arst_recv_rdy", {31'd0, a_recv_rdy}, 32'd0);
        tick();
        rst_n = 1'b1;
        expect_frame(8'h91, 8'h92, 8'h93, 8'h94);
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        recv_val = 1'b0;
        tick();
        tick();

        // Single-word frames
        c_recv_val = 1'b1;
        c_recv_msg = 8'h5A;
        @(negedge clk);
        chk("c_rdy_0", {31'd0, c_recv_rdy}, 32'd1);
        tick();
        chk("c_val_0", {31'd0, c_send_val}, 32'd1);
        chk("c_msg_0", {24'd0, c_send_msg}, 32'h5A);
        chk("c_cnt_0", {31'd0, c_count}, 32'd0);
        c_recv_msg = 8'hA5;
        @(negedge clk);
        chk("c_rdy_1", {31'd0, c_recv_rdy}, 32'd1);
        tick();
        chk("c_val_1", {31'd0, c_send_val}, 32'd1);
        chk("c_msg_1", {24'd0, c_send_msg}, 32'hA5);
        c_recv_val = 1'b0;
        tick();
        chk("c_val_idle", {31'd0, c_send_val}, 32'd0);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
